// File: rtl/noise_pkg.sv
// noise_pkg: shared constants for the noise step scheduler
package noise_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_CAPT = 2'd3;
  localparam int DEF_NUM_VOICES = 3;
  localparam int DEF_PERIOD_W = 10;
  localparam int LFSR_LAT = 2;
endpackage

// File: rtl/noise_rr_arbiter.sv
// noise_rr_arbiter: combinational round-robin pick of the first pending voice at or after ptr
module noise_rr_arbiter #(
  parameter int NUM_VOICES = 3,
  parameter int SEL_W = 2
) (
  input  logic [NUM_VOICES-1:0] pend,
  input  logic [SEL_W-1:0]      ptr,
  output logic                  grant_valid,
  output logic [SEL_W-1:0]      grant_idx
);
  localparam logic [SEL_W:0] NV = (SEL_W+1)'(NUM_VOICES);
  logic [NUM_VOICES-1:0] rot;
  logic [SEL_W-1:0] off;
  logic [SEL_W:0] sum;
  // rotate so bit 0 is the pointer position, then take the lowest set bit
  always_comb begin
    rot = NUM_VOICES'({pend, pend} >> ptr);
    off = '0;
    for (int k = NUM_VOICES - 1; k >= 0; k--) if (rot[k]) off = SEL_W'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    grant_valid = |pend;
    grant_idx = sum >= NV ? SEL_W'(sum - NV) : SEL_W'(sum);
  end
endmodule

// File: rtl/noise_step_sched.sv
// noise_step_sched: per-voice dividers and round-robin sharing of one noise LFSR
module noise_step_sched
  import noise_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  cfg_we,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [PERIOD_W-1:0]   cfg_period,
  input  logic                  cfg_en,
  output logic                  lfsr_step,
  input  logic                  lfsr_bit,
  output logic [NUM_VOICES-1:0] voice_noise,
  output logic [NUM_VOICES-1:0] overrun,
  output logic                  busy
);
  logic [1:0] state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d, g_q, g_d, g_nxt, arb_ptr, arb_idx;
  logic arb_valid, take, capt;
  logic [NUM_VOICES-1:0][PERIOD_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic [NUM_VOICES-1:0] en_q, en_d, pend_q, pend_d, ovr_q, ovr_d, noise_q, noise_d;
  logic wr, dis, set, clr;

  assign capt = state_q == S_CAPT;
  assign g_nxt = g_q == SEL_W'(NUM_VOICES - 1) ? '0 : g_q + 1'b1;
  // in CAPT the pointer already advances past the voice just served
  assign arb_ptr = capt ? g_nxt : ptr_q;
  assign take = arb_valid && (capt || state_q == S_IDLE);
  assign lfsr_step = state_q == S_STEP;
  assign busy = state_q != S_IDLE;
  assign voice_noise = noise_q;
  assign overrun = ovr_q;

  noise_rr_arbiter #(.NUM_VOICES(NUM_VOICES), .SEL_W(SEL_W)) u_arb (
    .pend(pend_q),
    .ptr(arb_ptr),
    .grant_valid(arb_valid),
    .grant_idx(arb_idx)
  );

  always_comb begin
    state_d = state_q == S_STEP ? S_WAIT : state_q == S_WAIT ? S_CAPT : take ? S_STEP : S_IDLE;
    ptr_d = arb_ptr;
    g_d = take ? arb_idx : g_q;
    period_d = period_q;
    en_d = en_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    ovr_d = ovr_q;
    noise_d = noise_q;
    wr = 1'b0;
    dis = 1'b0;
    set = 1'b0;
    clr = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      wr = cfg_we && cfg_sel == SEL_W'(v);
      dis = wr && !cfg_en;
      set = en_q[v] && tick && cnt_q[v] == '0;
      clr = take && arb_idx == SEL_W'(v);
      if (wr) begin
        period_d[v] = cfg_period;
        en_d[v] = cfg_en;
      end
      cnt_d[v] = dis ? '0 : (en_q[v] && tick) ? (set ? period_q[v] : cnt_q[v] - 1'b1) : cnt_q[v];
      pend_d[v] = dis ? 1'b0 : set ? 1'b1 : clr ? 1'b0 : pend_q[v];
      ovr_d[v] = wr ? 1'b0 : (set && pend_q[v] && !clr) ? 1'b1 : ovr_q[v];
      noise_d[v] = dis ? 1'b0 : (capt && g_q == SEL_W'(v) && en_q[v]) ? lfsr_bit : noise_q[v];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      g_q <= '0;
      period_q <= '0;
      en_q <= '0;
      cnt_q <= '0;
      pend_q <= '0;
      ovr_q <= '0;
      noise_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      g_q <= g_d;
      period_q <= period_d;
      en_q <= en_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      ovr_q <= ovr_d;
      noise_q <= noise_d;
    end
  end
endmodule

// File: tb/tb_noise_step_sched.sv
// tb_noise_step_sched: scoreboard bench; expected grant order is queued, each step drives a fresh bit and its capture is checked
module tb_noise_step_sched;
  localparam int NV = 3;
  localparam int PW = 10;
  localparam int SW = 2;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, cfg_we = 1'b0, cfg_en = 1'b0, lfsr_bit = 1'b0;
  logic [SW-1:0] cfg_sel = '0;
  logic [PW-1:0] cfg_period = '0;
  logic lfsr_step, busy;
  logic [NV-1:0] voice_noise, overrun;
  int n_tests = 0, n_fail = 0, ncyc = 0, nsteps = 0, last_step = 0, chk_cnt = 0, cv = 0;
  logic cb = 1'b0;
  logic [NV-1:0] exp_noise = '0, en_m = '0;
  int exp_q[$];
  int step_t[$];

  always #5 clk = ~clk;

  noise_step_sched #(.NUM_VOICES(NV), .PERIOD_W(PW), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_period(cfg_period), .cfg_en(cfg_en), .lfsr_step(lfsr_step), .lfsr_bit(lfsr_bit),
    .voice_noise(voice_noise), .overrun(overrun), .busy(busy)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, ncyc);
    end
  endtask

  // one clock: sample at negedge, score captures 3 clks after each step
  task automatic cyc();
    @(negedge clk);
    ncyc++;
    if (chk_cnt > 0) begin
      chk_cnt--;
      if (chk_cnt == 0) begin
        exp_noise[cv] = en_m[cv] & cb;
        check("noise", 32'(voice_noise), 32'(exp_noise));
      end
    end
    if (lfsr_step) begin
      nsteps++;
      last_step = ncyc;
      step_t.push_back(ncyc);
      check("sb_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        cv = exp_q.pop_front();
        cb = ~exp_noise[cv];
        lfsr_bit = cb;
        chk_cnt = 3;
      end
    end
  endtask

  task automatic cfg(int sel, int per, bit en);
    cfg_we = 1'b1;
    cfg_sel = SW'(sel);
    cfg_period = PW'(per);
    cfg_en = en;
    cyc();
    cfg_we = 1'b0;
    if (sel < NV) begin
      en_m[sel] = en;
      if (!en) exp_noise[sel] = 1'b0;
    end
  endtask

  task automatic pulse(int n, int gap);
    repeat (n) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      repeat (gap - 1) cyc();
    end
  endtask

  task automatic drain(int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_cnt = 0;
    exp_q.delete();
    step_t.delete();
    exp_noise = '0;
    en_m = '0;
  endtask

  task automatic wait_step();
    int n0 = nsteps;
    int k = 0;
    while (nsteps == n0 && k < 40) begin
      cyc();
      k++;
    end
    check("step_seen", 32'(nsteps - n0), 1);
  endtask

  initial begin
    int n1, t0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    check("rst_step", 32'(lfsr_step), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_noise", 32'(voice_noise), 0);
    check("rst_ovr", 32'(overrun), 0);
    rst = 1'b0;
    cfg(3, 0, 1'b1);
    pulse(3, 2);
    drain(6);
    check("bad_sel_no_step", 32'(nsteps), 0);
    check("idle_busy", 32'(busy), 0);

    n1 = nsteps;
    cfg(0, 2, 1'b1);
    repeat (2) exp_q.push_back(0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    t0 = ncyc;
    wait_step();
    check("latency", 32'(last_step), 32'(t0 + 1));
    drain(6);
    pulse(5, 8);
    drain(8);
    check("single_steps", 32'(nsteps - n1), 2);
    check("single_sb_empty", 32'(exp_q.size()), 0);

    do_reset();
    for (int v = 0; v < NV; v++) cfg(v, 0, 1'b1);
    repeat (2) for (int v = 0; v < NV; v++) exp_q.push_back(v);
    pulse(2, 9);
    drain(12);
    check("cont_steps", 32'(step_t.size()), 6);
    if (step_t.size() == 6)
      for (int i = 1; i < 6; i++) check("cont_spacing", 32'(step_t[i] - step_t[i-1]), 3);
    check("cont_ovr", 32'(overrun), 0);
    check("cont_sb_empty", 32'(exp_q.size()), 0);

    do_reset();
    for (int v = 0; v < NV; v++) cfg(v, 0, 1'b1);
    repeat (40) for (int v = 0; v < NV; v++) exp_q.push_back(v);
    pulse(10, 2);
    drain(15);
    check("ovr_all", 32'(overrun), 32'h7);
    check("ovr_idle", 32'(busy), 0);
    cfg(1, 0, 1'b1);
    check("ovr_clr1", 32'(overrun), 32'h5);

    do_reset();
    cfg(0, 0, 1'b1);
    exp_q.push_back(0);
    pulse(1, 1);
    drain(6);
    cfg(0, 0, 1'b0);
    cfg(2, 0, 1'b1);
    exp_q.push_back(2);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    wait_step();
    cyc();
    cfg(2, 0, 1'b0);
    drain(4);
    check("dis_noise2", 32'(voice_noise[2]), 0);
    cfg(0, 0, 1'b1);
    cfg(1, 0, 1'b1);
    exp_q.push_back(0);
    exp_q.push_back(1);
    pulse(1, 1);
    drain(10);
    check("ptr_wrap_sb_empty", 32'(exp_q.size()), 0);

    do_reset();
    for (int v = 0; v < NV; v++) cfg(v, 0, 1'b1);
    for (int v = 0; v < NV; v++) exp_q.push_back(v);
    pulse(1, 1);
    repeat (3) wait_step();
    check("pre_rst_noise", 32'(voice_noise), 32'h3);
    do_reset();
    check("midrst_step", 32'(lfsr_step), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_noise", 32'(voice_noise), 0);
    n1 = nsteps;
    drain(6);
    check("midrst_no_pend", 32'(nsteps - n1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/noise_step_sched.md
Name: noise_step_sched

Overview:
- Shares the single 16-bit noise LFSR among NUM_VOICES noise voices of the sound generator.
- Each voice has a programmable period divider clocked by the global prescaler tick. An expired divider raises a step request.
- A round-robin scheduler grants one request at a time, pulses the LFSR step enable, and latches the resulting noise bit into that voice's held output.
- Sits between the register interface (cfg_*) and the LFSR; voice_noise feeds the mixer.

Parameters:
NUM_VOICES, 3, number of noise voices sharing the LFSR (2..4)
PERIOD_W, 10, width of per-voice period register and divider counter
SEL_W, 2, width of cfg_sel (must be >= clog2(NUM_VOICES))

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
tick  in  1  prescaler strobe, one clk wide
cfg_we  in  1  config write strobe
cfg_sel  in  SEL_W  voice index for write; values >= NUM_VOICES are ignored
cfg_period  in  PERIOD_W  divider reload value; 0 = request on every tick
cfg_en  in  1  voice enable
lfsr_step  out  1  step enable to LFSR, one clk pulse per grant
lfsr_bit  in  1  registered LFSR noise output
voice_noise  out  NUM_VOICES  held noise bit per voice
overrun  out  NUM_VOICES  sticky: expiry while request still pending
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE; all period, enable, counter, pending and overrun registers 0; round-robin pointer set so voice 0 has highest priority. rst mid-grant aborts immediately; lfsr_step is 0 from the next cycle, and no capture occurs.
- Config: on cfg_we with valid cfg_sel:
  - period[sel] <= cfg_period; en[sel] <= cfg_en; overrun[sel] <= 0.
  - The counter is not reloaded; a new period takes effect at the next reload.
  - Writing cfg_en=0 clears counter[sel], pending[sel] and voice_noise[sel] in the same edge.
- Divider, per enabled voice, on tick:
  - If counter==0: counter <= period and pending <= 1. If pending was already 1 and is not being granted this cycle, overrun <= 1.
  - Otherwise counter <= counter-1.
  - Disabled voices ignore tick.
- Same-cycle events:
  - Expiry and grant-clear on the same voice in the same cycle: set wins, pending stays 1, no overrun.
  - Disable write and tick on the same voice: disable wins.
- FSM states are IDLE, STEP, WAIT, CAPT.
  - IDLE: if any pending, grant the first pending voice at or after the pointer (wrapping), clear its pending, store grant index g, then go to STEP. Otherwise stay in IDLE.
  - STEP: lfsr_step=1 for exactly this cycle, then WAIT.
  - WAIT: one cycle, then CAPT. The LFSR updates its register here.
  - CAPT: lfsr_bit is valid. voice_noise[g] <= lfsr_bit if en[g] is still 1, else unchanged (already cleared). Pointer <= g+1 mod NUM_VOICES. Arbitration is evaluated as in IDLE: if a request is pending, go directly to STEP with the new grant, otherwise go to IDLE.
- Latency: request in IDLE to voice_noise update is 4 edges (IDLE grant, STEP, WAIT, CAPT). Back-to-back grant period is 3 cycles.
- Wrap-around: the pointer wraps from NUM_VOICES-1 to 0. The counter reloads from period with no extra cycle.
- Fairness: a continuously pending voice waits at most NUM_VOICES-1 grants.

Decomposition:
- Shared package noise_pkg: FSM state encoding (2-bit localparams S_IDLE, S_STEP, S_WAIT, S_CAPT), default PERIOD_W and NUM_VOICES, LFSR capture latency constant (2).
- One sub-module, noise_rr_arbiter: combinational round-robin pick from the pending vector and pointer, producing grant_valid and grant_idx. Dividers and FSM stay in the top.

Test Plan:
- Reset then idle: rst high for 2 cycles with tick toggling -> all outputs 0, lfsr_step never asserted, busy=0.
- Single voice: voice 0 period=2, en=1, tick every 8 clks -> exactly one lfsr_step per 3 ticks. voice_noise[0] equals the lfsr_bit value sampled in CAPT, 3 clks after lfsr_step rises.
- Contention: voices 0,1,2 with period=0, tick every 9 clks -> grants in order 0,1,2,0,1,2, steps spaced 3 clks apart, overrun stays 000.
- Overrun: period=0 on all 3 voices, tick every 2 clks -> overrun bits go 1. A cfg write to voice 1 clears only overrun[1].
- Disable mid-grant: voice 2 granted, cfg_en=0 written during WAIT -> voice_noise[2]=0 after CAPT, and the pointer still advances to 0.
- Reset mid-operation: rst asserted in STEP -> next cycle lfsr_step=0, state IDLE, pending=000, voice_noise=000.
